// File: rtl/l32_adder_pipe.sv
// Two-stage valid/ready pipelined 32-bit adder with carry-out, signed overflow
// and a completed-transfer counter; the sum comes from a sparse-4 Ling adder.

// Ling prefix node: (G,P) o (G',P') = (G | P&G', P&P').
module l32_ling_node (
    input  logic g_hi_i,
    input  logic p_hi_i,
    input  logic g_lo_i,
    input  logic p_lo_i,
    output logic g_o,
    output logic p_o
);
    assign g_o = g_hi_i | (p_hi_i & g_lo_i);
    assign p_o = p_hi_i & p_lo_i;
endmodule

// 4-bit group Ling terms: H(4k+4) = G | P & H(4k). P uses the t bit just below
// the group, which is what makes the Ling recurrence shift by one position.
module l32_ling_grp (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       t_prev_i,
    output logic       g_o,
    output logic       p_o
);
    logic [3:0] g, t;
    assign g   = a_i & b_i;
    assign t   = a_i | b_i;
    assign g_o = g[3] | (t[2] & g[2]) | (t[2] & t[1] & g[1]) | (t[2] & t[1] & t[0] & g[0]);
    assign p_o = t[2] & t[1] & t[0] & t_prev_i;
endmodule

// 4-bit sum slice given the true carry into the group (flat sum-of-products).
module l32_sum4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] s_o
);
    logic [3:0] g, t, p;
    logic       c1, c2, c3;
    assign g  = a_i & b_i;
    assign t  = a_i | b_i;
    assign p  = a_i ^ b_i;
    assign c1 = g[0] | (t[0] & cin_i);
    assign c2 = g[1] | (t[1] & g[0]) | (t[1] & t[0] & cin_i);
    assign c3 = g[2] | (t[2] & g[1]) | (t[2] & t[1] & g[0]) | (t[2] & t[1] & t[0] & cin_i);
    assign s_o = p ^ {c3, c2, c1, cin_i};
endmodule

// 32-bit sparse-4 Ling adder: Kogge-Stone over 8 groups yields H at every 4th
// bit; the real carry into group k is t[4k-1] & H(4k).
module l32_ling_adder (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] s_o
);
    localparam int NG = 8;
    logic [31:0]   t;
    logic [NG-1:0] g0, p0, g1, p1, g2, p2, g3, p3;
    logic [NG-1:0] cin;

    assign t = a_i | b_i;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        l32_ling_grp u_grp (
            .a_i     (a_i[4*k+3:4*k]),
            .b_i     (b_i[4*k+3:4*k]),
            .t_prev_i((k == 0) ? 1'b0 : t[(k == 0) ? 0 : 4*k-1]),
            .g_o     (g0[k]),
            .p_o     (p0[k])
        );
    end

    for (genvar k = 0; k < NG; k++) begin : g_l1
        if (k >= 1) begin : g_n
            l32_ling_node u_n (.g_hi_i(g0[k]), .p_hi_i(p0[k]), .g_lo_i(g0[k-1]), .p_lo_i(p0[k-1]),
                               .g_o(g1[k]), .p_o(p1[k]));
        end else begin : g_c
            assign g1[k] = g0[k];
            assign p1[k] = p0[k];
        end
    end

    for (genvar k = 0; k < NG; k++) begin : g_l2
        if (k >= 2) begin : g_n
            l32_ling_node u_n (.g_hi_i(g1[k]), .p_hi_i(p1[k]), .g_lo_i(g1[k-2]), .p_lo_i(p1[k-2]),
                               .g_o(g2[k]), .p_o(p2[k]));
        end else begin : g_c
            assign g2[k] = g1[k];
            assign p2[k] = p1[k];
        end
    end

    for (genvar k = 0; k < NG; k++) begin : g_l3
        if (k >= 4) begin : g_n
            l32_ling_node u_n (.g_hi_i(g2[k]), .p_hi_i(p2[k]), .g_lo_i(g2[k-4]), .p_lo_i(p2[k-4]),
                               .g_o(g3[k]), .p_o(p3[k]));
        end else begin : g_c
            assign g3[k] = g2[k];
            assign p3[k] = p2[k];
        end
    end

    for (genvar k = 0; k < NG; k++) begin : g_sum
        if (k == 0) begin : g_c0
            assign cin[k] = 1'b0;
        end else begin : g_ck
            assign cin[k] = t[4*k-1] & g3[k-1];
        end
        l32_sum4 u_sum (
            .a_i  (a_i[4*k+3:4*k]),
            .b_i  (b_i[4*k+3:4*k]),
            .cin_i(cin[k]),
            .s_o  (s_o[4*k+3:4*k])
        );
    end
endmodule

module l32_adder_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      sum,
    output logic             cout,
    output logic             ovf,
    output logic [CNT_W-1:0] done_cnt
);
    logic             v1_q, v2_q;
    logic [31:0]      a1_q, b1_q;
    logic [31:0]      sum_q;
    logic             cout_q, ovf_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      sum_d;
    logic             cout_d, ovf_d;
    logic             adv2;

    l32_ling_adder u_add (.a_i(a1_q), .b_i(b1_q), .s_o(sum_d));

    assign cout_d = (a1_q[31] & b1_q[31]) | ((a1_q[31] ^ b1_q[31]) & ~sum_d[31]);
    assign ovf_d  = (a1_q[31] == b1_q[31]) & (sum_d[31] != a1_q[31]);
    assign cnt_d  = cnt_q + CNT_W'(1);

    // S2 advances when empty or draining; S1 may then refill in the same cycle.
    assign adv2     = !v2_q | out_ready;
    assign in_ready = !v1_q | adv2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            a1_q   <= '0;
            b1_q   <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (in_ready) begin
                v1_q <= in_valid;
                a1_q <= a;
                b1_q <= b;
            end
            if (adv2) begin
                v2_q   <= v1_q;
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
            if (v2_q && out_ready)
                cnt_q <= cnt_d;
        end
    end

    assign out_valid = v2_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign done_cnt  = cnt_q;
endmodule

// File: tb/tb_l32_adder_pipe.sv
// Randomized and directed bench for l32_adder_pipe against an arithmetic
// reference model with an in-order expected-result queue.
module tb_l32_adder_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] a, b;
    logic        out_valid, out_ready;
    logic [31:0] sum;
    logic        cout, ovf;
    logic [3:0]  done_cnt;

    l32_adder_pipe #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    int          nvec = 0, nerr = 0;
    logic [33:0] q[$];
    logic [3:0]  dcnt = 4'd0;
    logic        held = 1'b0;
    logic [33:0] held_res;
    logic        ov_s, ir_s;
    logic [33:0] res_s;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {sum, cout, ovf} from plain wide arithmetic.
    function automatic logic [33:0] ref_res(input logic [31:0] x, input logic [31:0] y);
        logic [32:0] w;
        longint      s;
        w = {1'b0, x} + {1'b0, y};
        s = longint'($signed(x)) + longint'($signed(y));
        return {w[31:0], w[32], s != longint'($signed(w[31:0]))};
    endfunction

    // One cycle: drive at negedge, sample 1ns later, update model for the coming edge.
    task automatic step(input logic iv, input logic [31:0] ai, input logic [31:0] bi, input logic ordy);
        logic [33:0] e;
        @(negedge clk);
        in_valid = iv; a = ai; b = bi; out_ready = ordy;
        #1;
        ov_s  = out_valid;
        ir_s  = in_ready;
        res_s = {sum, cout, ovf};
        chk("in_ready", 64'(in_ready), 64'(!(q.size() == 2 && !ordy)));
        chk("done_cnt", 64'(done_cnt), 64'(dcnt));
        if (held) chk("hold", 64'({out_valid, sum, cout, ovf}), 64'({1'b1, held_res}));
        held     = out_valid && !ordy;
        held_res = {sum, cout, ovf};
        if (out_valid && ordy) begin
            chk("out_has_pending", 64'(q.size() != 0), 64'(1));
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("result", 64'({sum, cout, ovf}), 64'(e));
            end
            dcnt++;
        end
        if (iv && in_ready) q.push_back(ref_res(ai, bi));
    endtask

    task automatic single(input logic [31:0] x, input logic [31:0] y, input logic [33:0] exp);
        step(1'b1, x, y, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        chk("lat_cycle1", 64'(ov_s), 64'(0));
        step(1'b0, 32'h0, 32'h0, 1'b1);
        chk("lat_cycle2", 64'(ov_s), 64'(1));
        chk("directed_res", 64'(res_s), 64'(exp));
    endtask

    logic [31:0] pa[8], pb[8];
    int          sent;
    logic        saw_stall;

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_done", 64'(done_cnt), 64'(0));
        chk("rst_sum", 64'({sum, cout, ovf}), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst = 1'b0;

        single(32'h0000_0001, 32'h0000_0002, {32'h0000_0003, 1'b0, 1'b0});
        step(1'b0, 32'h0, 32'h0, 1'b1);
        chk("done_one", 64'(done_cnt), 64'(1));
        single(32'hFFFF_FFFF, 32'h0000_0001, {32'h0000_0000, 1'b1, 1'b0});
        single(32'h7FFF_FFFF, 32'h0000_0001, {32'h8000_0000, 1'b0, 1'b1});
        single(32'h8000_0000, 32'h8000_0000, {32'h0000_0000, 1'b1, 1'b1});

        // Back-to-back stream with a downstream stall on cycles 3..6.
        for (int i = 0; i < 8; i++) begin pa[i] = $urandom; pb[i] = $urandom; end
        sent = 0; saw_stall = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (sent == 8 && q.size() == 0) break;
            step(sent < 8, pa[sent % 8], pb[sent % 8], !(c >= 3 && c <= 6));
            if (!ir_s) saw_stall = 1'b1;
            if (sent < 8 && ir_s) sent++;
        end
        chk("bp_sent", 64'(sent), 64'(8));
        chk("bp_stall_seen", 64'(saw_stall), 64'(1));
        chk("bp_drained", 64'(q.size()), 64'(0));

        // Random valid/ready traffic, including corner operands.
        for (int c = 0; c < 300; c++) begin
            logic [31:0] x, y;
            x = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            y = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            step($urandom_range(0, 3) != 0, x, y, $urandom_range(0, 2) != 0);
        end
        for (int c = 0; c < 4; c++) step(1'b0, 32'h0, 32'h0, 1'b1);
        chk("rand_drained", 64'(q.size()), 64'(0));

        // Reset with two transactions in flight, asserted between edges.
        step(1'b1, $urandom, $urandom, 1'b0);
        step(1'b1, $urandom, $urandom, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_done", 64'(done_cnt), 64'(0));
        chk("mid_rst_sum", 64'({sum, cout, ovf}), 64'(0));
        q.delete(); dcnt = 4'd0; held = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 32'h0, 32'h0, 1'b1);
        chk("post_rst_in_ready", 64'(ir_s), 64'(1));
        chk("post_rst_out_valid", 64'(ov_s), 64'(0));
        for (int c = 0; c < 3; c++) step(1'b0, 32'h0, 32'h0, 1'b1);

        // 17 transfers through a 4-bit counter wrap it to 1.
        for (int c = 0; c < 17; c++) step(1'b1, $urandom, $urandom, 1'b1);
        for (int c = 0; c < 4; c++) step(1'b0, 32'h0, 32'h0, 1'b1);
        chk("cnt_wrap", 64'(done_cnt), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
